// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU holding FIFOs feeding an N-wide, LSB-packed, round-robin CDB.
// Define CDB_BYPASS_EN to let an empty FIFO's incoming result compete in its push cycle.
module cdb_arbiter #(
   parameter int N      = 2,
   parameter int NUM_FU = 4,
   parameter int DEPTH  = 2,
   parameter int PRF    = 64,
   parameter int PRF_W  = $clog2(PRF)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         squash,
   input  logic [NUM_FU-1:0]            fu_valid,
   input  logic [NUM_FU-1:0][31:0]      fu_data,
   input  logic [NUM_FU-1:0][PRF_W-1:0] fu_prf_idx,
   output logic [NUM_FU-1:0]            fu_ready,
   output logic [N-1:0]                 CDB_valid,
   output logic [N-1:0][31:0]           CDB_Data,
   output logic [N-1:0][PRF_W-1:0]      CDB_PRF_idx,
   output logic [$clog2(N):0]           cdb_count
);

   localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;
   localparam int GCNT_W = $clog2(N) + 1;

   logic [31:0]      mem_data [NUM_FU][DEPTH];
   logic [PRF_W-1:0] mem_tag  [NUM_FU][DEPTH];
   logic [PTR_W-1:0] rd_ptr   [NUM_FU];
   logic [PTR_W-1:0] wr_ptr   [NUM_FU];
   logic [CNT_W-1:0] count    [NUM_FU];
   logic [FU_W-1:0]  rr_ptr;

   logic [NUM_FU-1:0]            has_entry;
   logic [NUM_FU-1:0]            push;
   logic [NUM_FU-1:0]            bypass_cand;
   logic [NUM_FU-1:0]            cand;
   logic [NUM_FU-1:0]            grant;
   logic [NUM_FU-1:0]            wr_en;
   logic [NUM_FU-1:0]            rd_en;
   logic [NUM_FU-1:0][31:0]      cand_data;
   logic [NUM_FU-1:0][PRF_W-1:0] cand_tag;

   logic [N-1:0]            slot_valid;
   logic [N-1:0][31:0]      slot_data;
   logic [N-1:0][PRF_W-1:0] slot_tag;
   logic [GCNT_W-1:0]       n_granted;
   logic [FU_W-1:0]         idx;
   logic [FU_W-1:0]         last_fu;
   logic [FU_W-1:0]         rr_next;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready comes only from registered occupancy, so a same-cycle pop never opens a full FIFO.
   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign has_entry[i] = (count[i] != '0);
      assign fu_ready[i]  = reset && (count[i] < CNT_W'(DEPTH));
      assign push[i]      = fu_valid[i] && fu_ready[i];
`ifdef CDB_BYPASS_EN
      assign bypass_cand[i] = push[i] && !has_entry[i];
`else
      assign bypass_cand[i] = 1'b0;
`endif
      assign cand[i]      = has_entry[i] || bypass_cand[i];
      assign cand_data[i] = has_entry[i] ? mem_data[i][rd_ptr[i]] : fu_data[i];
      assign cand_tag[i]  = has_entry[i] ? mem_tag[i][rd_ptr[i]]  : fu_prf_idx[i];
      assign wr_en[i]     = push[i] && !(grant[i] && bypass_cand[i]);
      assign rd_en[i]     = grant[i] && has_entry[i];
   end

   // Scan from rr_ptr, handing the k-th candidate found to CDB slot k.
   always_comb begin
      grant      = '0;
      slot_valid = '0;
      slot_data  = '0;
      slot_tag   = '0;
      n_granted  = '0;
      last_fu    = rr_ptr;
      idx        = rr_ptr;
      for (int o = 0; o < NUM_FU; o++) begin
         idx = FU_W'((int'(rr_ptr) + o) % NUM_FU);
         if (cand[idx] && (n_granted < GCNT_W'(N))) begin
            grant[idx]                        = 1'b1;
            slot_valid[n_granted[SLOT_W-1:0]] = 1'b1;
            slot_data[n_granted[SLOT_W-1:0]]  = cand_data[idx];
            slot_tag[n_granted[SLOT_W-1:0]]   = cand_tag[idx];
            last_fu                           = idx;
            n_granted                         = n_granted + 1'b1;
         end
      end
      rr_next = (last_fu == FU_W'(NUM_FU - 1)) ? '0 : last_fu + 1'b1;
   end

   // Reset and squash both drop everything buffered and this cycle's grants.
   always_ff @(posedge clock) begin
      if (!reset || squash) begin
         for (int i = 0; i < NUM_FU; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr      <= '0;
         CDB_valid   <= '0;
         CDB_Data    <= '0;
         CDB_PRF_idx <= '0;
         cdb_count   <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (wr_en[i]) begin
               mem_data[i][wr_ptr[i]] <= fu_data[i];
               mem_tag[i][wr_ptr[i]]  <= fu_prf_idx[i];
               wr_ptr[i]              <= ptr_inc(wr_ptr[i]);
            end
            if (rd_en[i]) begin
               rd_ptr[i] <= ptr_inc(rd_ptr[i]);
            end
            count[i] <= count[i] + CNT_W'(wr_en[i]) - CNT_W'(rd_en[i]);
         end
         if (|grant) begin
            rr_ptr <= rr_next;
         end
         CDB_valid   <= slot_valid;
         CDB_Data    <= slot_data;
         CDB_PRF_idx <= slot_tag;
         cdb_count   <= n_granted;
      end
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects completed results from the function units and broadcasts up to `N` of them per cycle on the CDB.
- The CDB feeds the reservation stations, PRF and ROB.
- Each FU has a small holding FIFO, so an FU that loses arbitration does not stall on its first conflict.
- Round-robin arbitration across FUs; CDB slots are packed from the LSB (valid patterns 0, 1, 11, ...).

Parameters:
- N, `N (2): CDB width, i.e. max broadcasts per cycle.
- NUM_FU, 4: number of FU result ports.
- DEPTH, 2: holding FIFO entries per FU (power of 2, >= 1).
- PRF_W, $clog2(`PRF): PRF tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clock).
- squash  in  1  pipeline flush; discard all buffered and in-flight results.
- fu_valid  in  NUM_FU  FU i presents a result this cycle.
- fu_data  in  NUM_FU x 32  result values.
- fu_prf_idx  in  NUM_FU x PRF_W  destination PRF tags.
- fu_ready  out  NUM_FU  FIFO i can accept this cycle.
- CDB_valid  out  N  broadcast slot valid, LSB-packed.
- CDB_Data  out  N x 32  broadcast values.
- CDB_PRF_idx  out  N x PRF_W  broadcast tags.
- cdb_count  out  $clog2(N)+1  number of valid CDB slots this cycle.

Behaviour:
- Reset (reset==0 at posedge):
  - All FIFOs empty; rr_ptr=0.
  - CDB_valid=0, CDB_Data=0, CDB_PRF_idx=0, cdb_count=0.
  - fu_ready is forced 0 while reset==0 and is all-ones in the first cycle after release.
- Accept:
  - fu_ready[i] = (count_i < DEPTH), taken from registered state only; it does not depend on a same-cycle pop.
  - A push occurs when fu_valid[i] && fu_ready[i].
  - fu_valid while !fu_ready is ignored (protocol error). The FU holds its result and retries.
- Arbitration (combinational, each cycle, over eligible FIFO heads):
  - Scan FUs starting at rr_ptr, wrapping modulo NUM_FU.
  - Grant the first up-to-N non-empty heads, at most one entry per FU per cycle.
  - The k-th grant goes to CDB slot k, so slot 0 always holds the first grant.
  - A granted head is popped.
- rr_ptr update: set to (index of last granted FU + 1) mod NUM_FU. Unchanged when nothing is granted.
- CDB outputs are registered:
  - Grants in cycle t appear on CDB_* in cycle t+1 and are held for exactly one cycle.
  - Unused slots have valid=0 and data/tag=0.
  - cdb_count equals popcount(CDB_valid).
- Latency: an FU push in cycle t is eligible in t+1 and broadcast in t+2. With the optional feature, an FU push can be broadcast in t+1.
- Simultaneous push and pop on the same FIFO is allowed and count is unchanged. A full FIFO cannot accept until the cycle after a pop.
- Pointers: FIFO read/write pointers wrap modulo DEPTH. count is DEPTH-width+1 bits and never exceeds DEPTH.
- Ordering: results from one FU are broadcast in push order. No ordering is guaranteed across FUs.
- Squash (registered effect), when squash==1 at posedge:
  - All FIFOs are emptied and rr_ptr=0.
  - CDB_valid=0 next cycle.
  - Pushes in the squash cycle are discarded.
  - Grants computed in the squash cycle are not broadcast.
- reset takes precedence over squash.
- Reset mid-operation: all buffered results are lost. No broadcast in the cycle after reset is sampled.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined:
  - An FU whose FIFO is empty and which pushes in cycle t is an arbitration candidate in cycle t.
  - The candidate is its incoming result, in the FU's normal round-robin position.
  - If granted, the result goes straight to the CDB registers and is broadcast in t+1; it is not written into the FIFO.
  - If not granted, it is written into the FIFO as normal.
- Undefined: only FIFO heads (registered state) are candidates, giving a minimum latency of 2 cycles.
- fu_ready semantics are identical in both builds.

Test Plan:
- Reset hold / release:
  - Stimulus: reset=0 for 3 cycles, with fu_valid=4'b1111 during reset.
  - Required: no pushes; CDB_valid=0; fu_ready=0 during reset; fu_ready=4'b1111 on the cycle after release.
- Single result:
  - Stimulus: FU2 pushes data 0xDEADBEEF, tag 17 at cycle t.
  - Required (no bypass): CDB_valid=2'b01, CDB_Data[0]=0xDEADBEEF, CDB_PRF_idx[0]=17 at t+2, cdb_count=1; CDB_valid=0 at t+3.
  - Required (CDB_BYPASS_EN): the same broadcast at t+1.
- Round-robin fairness:
  - Stimulus: all 4 FUs push one result each at cycle t, with rr_ptr=0.
  - Required (no bypass): FU0 and FU1 in slots 0/1 at t+2; FU2 and FU3 at t+3; rr_ptr=0 afterwards.
- Back-pressure:
  - Stimulus: FU0 pushes every cycle, tags 1,2,3,..., while FU1-3 also push continuously.
  - Required:
    - fu_ready[0] deasserts when count=DEPTH=2.
    - No tag is lost or duplicated.
    - FU0 tags appear on the CDB in increasing order.
    - Each FU gets at least one grant every 2 cycles.
- Squash mid-stream:
  - Stimulus: fill all FIFOs, then squash=1 for 1 cycle while FU1 pushes tag 9.
  - Required: CDB_valid=0 on the following cycle; tag 9 is never broadcast; fu_ready=4'b1111 after the squash.
- Simultaneous push/pop at full:
  - Stimulus: FU3 FIFO holds 2 entries, is granted, and FU3 does not push.
  - Required: fu_ready[3] is 0 in the grant cycle and 1 in the next cycle; count goes 2 -> 1.
